// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and the matching receiver:
//   - parity_e   : parity selection (NONE, EVEN, ODD)
//   - tx_state_e : transmitter frame-sequencing states
//   - calc_scale : bit period in clocks from clock MHz and line bit rate
//   - parity_bit : parity bit value for a data byte under a parity mode
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Bit period in clocks, integer-truncated. A zero or negative bit rate
  // yields 0 so that the caller's "scale < 2" elaboration check trips.
  function automatic int calc_scale(input int clk_mhz, input int boadrate);
    longint hz;
    hz = longint'(clk_mhz) * 64'sd1000000;
    if (boadrate <= 0) begin
      return 0;
    end
    return int'(hz / longint'(boadrate));
  endfunction

  // Even parity makes the total count of ones (data + parity) even;
  // odd parity is its inverse. NONE returns the even value (unused).
  function automatic logic parity_bit(input logic [7:0] bits, input parity_e mode);
    return (^bits) ^ (mode == ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period down-counter. A load reloads the counter to scale-1; otherwise
// it counts down and rests at zero. tick is high while the counter is zero,
// so a bit started by a load lasts exactly `scale` clocks.
// Ports:
//   clk   in  system clock, rising edge
//   rst_n in  asynchronous reset, active low (counter cleared)
//   load  in  start a new bit period on this edge
//   tick  out last clock of the current bit period
// -----------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int scale = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tick
);

  localparam int CNT_W = (scale < 2) ? 1 : $clog2(scale);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(scale - 1);

  if (scale < 2) begin : g_bad_scale
    $error("uart_baud_gen: scale must be at least 2");
  end

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= RELOAD;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign tick = (cnt_reg == '0);

endmodule

// File: rtl/uart_tx_reader.sv
// -----------------------------------------------------------------------------
// uart_tx_reader
// UART transmitter: start bit, 8 data bits LSB first, optional parity bit,
// 1 or 2 stop bits. A one-entry holding register lets the producer hand over
// the next byte while the current frame shifts out, so consecutive frames
// follow each other without an idle bit.
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous reset, active low; aborts any frame in flight
//   data    in   [7:0] byte to send, sampled when valid && ready
//   valid   in   producer has a byte on data
//   ready   out  holding register empty
//   tx      out  serial line, idle high, registered
//   busy    out  a frame is on the line (START through last STOP)
//   tx_done out  one-cycle pulse in the last clock of the last stop bit
// -----------------------------------------------------------------------------
module uart_tx_reader
  import uart_pkg::*;
#(
  parameter int clk_mhz     = 50,
  parameter int boadrate    = 9600,
  parameter int parity_mode = 0,
  parameter int stop_bits   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int      SCALE      = calc_scale(clk_mhz, boadrate);
  localparam parity_e PARITY_SEL = parity_e'(parity_mode[1:0]);
  // Index of the final stop bit (0 for one stop bit, 1 for two).
  localparam logic    STOP_LAST  = (stop_bits == 2);

  if (SCALE < 2) begin : g_bad_scale
    $error("uart_tx_reader: clk_mhz/boadrate gives a bit period below 2 clocks");
  end
  if ((parity_mode < 0) || (parity_mode > 2)) begin : g_bad_parity
    $error("uart_tx_reader: parity_mode must be 0, 1 or 2");
  end
  if ((stop_bits != 1) && (stop_bits != 2)) begin : g_bad_stop
    $error("uart_tx_reader: stop_bits must be 1 or 2");
  end

  tx_state_e  state_reg, state_next;
  logic [7:0] hold_reg;
  logic       hold_full_reg;
  logic [7:0] shift_reg, shift_next;
  logic [2:0] bit_idx_reg, bit_idx_next;
  logic       stop_idx_reg, stop_idx_next;
  logic       tx_reg, tx_next;

  logic       accept;   // byte handed over on this edge
  logic       take;     // FSM moves the held byte into the shift register
  logic       load;     // a new bit period starts on this edge
  logic       tick;     // last clock of the current bit period

  uart_baud_gen #(
    .scale(SCALE)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .tick (tick)
  );

  // ---------------------------------------------------------------------------
  // Holding register. ready is low while it is full, so an accept and a take
  // can never land on the same edge.
  // ---------------------------------------------------------------------------
  assign ready  = !hold_full_reg;
  assign accept = valid && !hold_full_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
    end else begin
      if (accept) begin
        hold_reg      <= data;
        hold_full_reg <= 1'b1;
      end else if (take) begin
        hold_full_reg <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame sequencer: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_idx_reg  <= '0;
      stop_idx_reg <= 1'b0;
      tx_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_idx_reg  <= bit_idx_next;
      stop_idx_reg <= stop_idx_next;
      tx_reg       <= tx_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame sequencer: next state. Every transition into a bit state also
  // reloads the baud counter, which is what makes each bit exactly one period.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_idx_next  = bit_idx_reg;
    stop_idx_next = stop_idx_reg;
    take          = 1'b0;
    load          = 1'b0;
    tx_done       = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (hold_full_reg) begin
          take       = 1'b1;
          shift_next = hold_reg;
          load       = 1'b1;
          state_next = START;
        end
      end

      START: begin
        if (tick) begin
          load         = 1'b1;
          bit_idx_next = 3'd0;
          state_next   = DATA;
        end
      end

      DATA: begin
        if (tick) begin
          load = 1'b1;
          if (bit_idx_reg == 3'd7) begin
            stop_idx_next = 1'b0;
            state_next    = (PARITY_SEL != NONE) ? PARITY : STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end

      PARITY: begin
        if (tick) begin
          load          = 1'b1;
          stop_idx_next = 1'b0;
          state_next    = STOP;
        end
      end

      STOP: begin
        if (tick) begin
          if (stop_idx_reg != STOP_LAST) begin
            load          = 1'b1;
            stop_idx_next = 1'b1;
          end else begin
            tx_done = 1'b1;
            // A byte already waiting goes straight to START: no idle gap.
            if (hold_full_reg) begin
              take       = 1'b1;
              shift_next = hold_reg;
              load       = 1'b1;
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Line level is decoded from the next-state values and registered, so tx
  // changes on the same edge as the state it belongs to and stays glitch-free.
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[bit_idx_next];
      PARITY:  tx_next = parity_bit(shift_next, PARITY_SEL);
      default: tx_next = 1'b1;
    endcase
  end

  assign tx   = tx_reg;
  assign busy = (state_reg != IDLE);

endmodule
